// File: rtl/sti_rx.sv
// sti_rx: STI serial-to-parallel receiver.
// Captures one 8/16/24/32-bit serial frame and recovers the 16-bit parallel word.
// Delivers the word with a one-cycle po_valid pulse and a running word index.
// Optional feature: define STI_RX_PAD_CHECK_EN to flag nonzero pad bits of
// 24/32-bit frames on po_err.
module sti_rx (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        si_data,
    input  logic        si_valid,
    input  logic [1:0]  rx_length,
    input  logic        rx_fill,
    input  logic        rx_msb,
    input  logic        rx_low,
    output logic [15:0] po_data,
    output logic        po_valid,
    output logic        po_err,
    output logic [7:0]  po_index,
    output logic        rx_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] sr_q, sr_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [5:0]  cnt_inc_s;
    logic [1:0]  cfg_len_q, cfg_len_d;
    logic        cfg_fill_q, cfg_fill_d;
    logic        cfg_msb_q, cfg_msb_d;
    logic        cfg_low_q, cfg_low_d;
    logic [15:0] po_data_q, po_data_d;
    logic        po_valid_q, po_valid_d;
    logic        po_err_q, po_err_d;
    logic [7:0]  po_index_q, po_index_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic        rx_busy_q, rx_busy_d;
    logic [31:0] frame_s;

    // Number of bits in a frame for a given length code.
    function automatic logic [5:0] frame_bits(input logic [1:0] len);
        logic [5:0] n;
        case (len)
            2'b00:   n = 6'd8;
            2'b01:   n = 6'd16;
            2'b10:   n = 6'd24;
            default: n = 6'd32;
        endcase
        return n;
    endfunction

    // Frame word F, zero-extended: low L bits of sr (MSB-first) or top L bits (LSB-first).
    function automatic logic [31:0] frame_word(input logic [31:0] sr, input logic [1:0] len,
                                               input logic msb);
        logic [31:0] f;
        if (msb) begin
            case (len)
                2'b00:   f = {24'h00_0000, sr[7:0]};
                2'b01:   f = {16'h0000, sr[15:0]};
                2'b10:   f = {8'h00, sr[23:0]};
                default: f = sr;
            endcase
        end else begin
            case (len)
                2'b00:   f = {24'h00_0000, sr[31:24]};
                2'b01:   f = {16'h0000, sr[31:16]};
                2'b10:   f = {8'h00, sr[31:8]};
                default: f = sr;
            endcase
        end
        return f;
    endfunction

    // Data field of F placed into the 16-bit output word.
    function automatic logic [15:0] extract_word(input logic [31:0] f, input logic [1:0] len,
                                                 input logic fill, input logic low);
        logic [15:0] w;
        case (len)
            2'b00:   w = low ? {f[7:0], 8'h00} : {8'h00, f[7:0]};
            2'b01:   w = f[15:0];
            2'b10:   w = fill ? f[23:8] : f[15:0];
            default: w = fill ? f[31:16] : f[15:0];
        endcase
        return w;
    endfunction

`ifdef STI_RX_PAD_CHECK_EN
    // High when any non-data bit of a 24/32-bit frame is set.
    function automatic logic pad_nonzero(input logic [31:0] f, input logic [1:0] len,
                                         input logic fill);
        logic bad;
        case (len)
            2'b10:   bad = fill ? (f[7:0] != 8'h00) : (f[23:16] != 8'h00);
            2'b11:   bad = fill ? (f[15:0] != 16'h0000) : (f[31:16] != 16'h0000);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction
`endif

    assign frame_s   = frame_word(sr_q, cfg_len_q, cfg_msb_q);
    assign cnt_inc_s = cnt_q + 6'd1;

    // Next-state, datapath and output computation for the receive FSM.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        cfg_len_d  = cfg_len_q;
        cfg_fill_d = cfg_fill_q;
        cfg_msb_d  = cfg_msb_q;
        cfg_low_d  = cfg_low_q;
        po_data_d  = po_data_q;
        po_valid_d = 1'b0;
        po_err_d   = 1'b0;
        po_index_d = po_index_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (si_valid) begin
                    state_d    = ST_SHIFT;
                    cfg_len_d  = rx_length;
                    cfg_fill_d = rx_fill;
                    cfg_msb_d  = rx_msb;
                    cfg_low_d  = rx_low;
                    sr_d       = rx_msb ? {31'h0000_0000, si_data} : {si_data, 31'h0000_0000};
                    cnt_d      = 6'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (si_valid) begin
                    sr_d  = cfg_msb_q ? {sr_q[30:0], si_data} : {si_data, sr_q[31:1]};
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == frame_bits(cfg_len_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    // Frame ended early: report and discard.
                    po_err_d = 1'b1;
                    cnt_d    = 6'd0;
                    state_d  = ST_IDLE;
                end
            end
            ST_DONE: begin
                po_data_d  = extract_word(frame_s, cfg_len_q, cfg_fill_q, cfg_low_q);
                po_valid_d = 1'b1;
                po_index_d = word_cnt_q;
                word_cnt_d = word_cnt_q + 8'd1;
                cnt_d      = 6'd0;
`ifdef STI_RX_PAD_CHECK_EN
                po_err_d   = pad_nonzero(frame_s, cfg_len_q, cfg_fill_q);
`endif
                if (si_valid) begin
                    // Overrun: word still delivered, remaining bits are drained.
                    po_err_d = 1'b1;
                    state_d  = ST_DRAIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (si_valid) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 6'd0;
            end
        endcase
        rx_busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and registered-output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sr_q       <= 32'h0000_0000;
            cnt_q      <= 6'd0;
            cfg_len_q  <= 2'b00;
            cfg_fill_q <= 1'b0;
            cfg_msb_q  <= 1'b0;
            cfg_low_q  <= 1'b0;
            po_data_q  <= 16'h0000;
            po_valid_q <= 1'b0;
            po_err_q   <= 1'b0;
            po_index_q <= 8'd0;
            word_cnt_q <= 8'd0;
            rx_busy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            cfg_len_q  <= cfg_len_d;
            cfg_fill_q <= cfg_fill_d;
            cfg_msb_q  <= cfg_msb_d;
            cfg_low_q  <= cfg_low_d;
            po_data_q  <= po_data_d;
            po_valid_q <= po_valid_d;
            po_err_q   <= po_err_d;
            po_index_q <= po_index_d;
            word_cnt_q <= word_cnt_d;
            rx_busy_q  <= rx_busy_d;
        end
    end

    assign po_data  = po_data_q;
    assign po_valid = po_valid_q;
    assign po_err   = po_err_q;
    assign po_index = po_index_q;
    assign rx_busy  = rx_busy_q;

endmodule

// File: tb/tb_sti_rx.sv
// tb_sti_rx: directed-vector bench for sti_rx.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sti_rx;

    logic        clk;
    logic        reset_n;
    logic        si_data;
    logic        si_valid;
    logic [1:0]  rx_length;
    logic        rx_fill;
    logic        rx_msb;
    logic        rx_low;
    logic [15:0] po_data;
    logic        po_valid;
    logic        po_err;
    logic [7:0]  po_index;
    logic        rx_busy;

    int          n_checks;
    int          n_errors;
    logic [7:0]  exp_idx;
    logic        pad_err_exp;

    sti_rx dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .si_data   (si_data),
        .si_valid  (si_valid),
        .rx_length (rx_length),
        .rx_fill   (rx_fill),
        .rx_msb    (rx_msb),
        .rx_low    (rx_low),
        .po_data   (po_data),
        .po_valid  (po_valid),
        .po_err    (po_err),
        .po_index  (po_index),
        .rx_busy   (rx_busy)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input logic [1:0] len, input logic fill, input logic msb,
                           input logic low);
        rx_length = len;
        rx_fill   = fill;
        rx_msb    = msb;
        rx_low    = low;
    endtask

    // Send nbits of f in the chosen order, then 'extra' one-bits, then drop si_valid.
    task automatic send_frame(input logic [31:0] f, input int nbits, input logic msb,
                              input int extra);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            si_valid = 1'b1;
            si_data  = msb ? f[nbits-1-i] : f[i];
        end
        for (int i = 0; i < extra; i++) begin
            @(negedge clk);
            si_valid = 1'b1;
            si_data  = 1'b1;
        end
        @(negedge clk);
        si_valid = 1'b0;
        si_data  = 1'b0;
    endtask

    // Called right after send_frame: checks the one-cycle delivery pulse.
    task automatic expect_word(input string tag, input logic [15:0] data, input logic err);
        check({tag, "_early"}, {31'h0, po_valid}, 32'h0);
        @(negedge clk);
        check({tag, "_valid"}, {31'h0, po_valid}, 32'h1);
        check({tag, "_data"}, {16'h0, po_data}, {16'h0, data});
        check({tag, "_index"}, {24'h0, po_index}, {24'h0, exp_idx});
        check({tag, "_err"}, {31'h0, po_err}, {31'h0, err});
        exp_idx = exp_idx + 8'd1;
        @(negedge clk);
        check({tag, "_vdrop"}, {31'h0, po_valid}, 32'h0);
        check({tag, "_edrop"}, {31'h0, po_err}, 32'h0);
        check({tag, "_idle"}, {31'h0, rx_busy}, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_idx  = 8'd0;
`ifdef STI_RX_PAD_CHECK_EN
        pad_err_exp = 1'b1;
`else
        pad_err_exp = 1'b0;
`endif
        reset_n  = 1'b0;
        si_data  = 1'b0;
        si_valid = 1'b0;
        set_cfg(2'b01, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_data", {16'h0, po_data}, 32'h0);
        check("rst_valid", {31'h0, po_valid}, 32'h0);
        check("rst_err", {31'h0, po_err}, 32'h0);
        check("rst_index", {24'h0, po_index}, 32'h0);
        check("rst_busy", {31'h0, rx_busy}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // 16-bit MSB-first.
        set_cfg(2'b01, 1'b0, 1'b1, 1'b0);
        send_frame(32'h0000_A5C3, 16, 1'b1, 0);
        expect_word("w16", 16'hA5C3, 1'b0);

        // 8-bit LSB-first, both byte lanes.
        set_cfg(2'b00, 1'b0, 1'b0, 1'b1);
        send_frame(32'h0000_003C, 8, 1'b0, 0);
        expect_word("w8hi", 16'h3C00, 1'b0);
        set_cfg(2'b00, 1'b0, 1'b0, 1'b0);
        send_frame(32'h0000_003C, 8, 1'b0, 0);
        expect_word("w8lo", 16'h003C, 1'b0);

        // 24-bit MSB-first, both fills; config changed mid-frame must not matter.
        set_cfg(2'b10, 1'b0, 1'b1, 1'b0);
        send_frame(32'h0000_BEEF, 24, 1'b1, 0);
        expect_word("w24f0", 16'hBEEF, 1'b0);
        set_cfg(2'b10, 1'b1, 1'b1, 1'b0);
        fork
            send_frame(32'h00BE_EF00, 24, 1'b1, 0);
            begin
                repeat (3) @(negedge clk);
                set_cfg(2'b01, 1'b0, 1'b0, 1'b1);
            end
        join
        expect_word("w24f1", 16'hBEEF, 1'b0);

        // 32-bit LSB-first, upper fill.
        set_cfg(2'b11, 1'b1, 1'b0, 1'b0);
        send_frame(32'h1234_0000, 32, 1'b0, 0);
        expect_word("w32", 16'h1234, 1'b0);

        // Truncation after 10 of 16 bits.
        set_cfg(2'b01, 1'b0, 1'b1, 1'b0);
        send_frame(32'h0000_02AB, 10, 1'b1, 0);
        @(negedge clk);
        check("trunc_err", {31'h0, po_err}, 32'h1);
        check("trunc_valid", {31'h0, po_valid}, 32'h0);
        check("trunc_index", {24'h0, po_index}, {24'h0, exp_idx - 8'd1});
        check("trunc_data", {16'h0, po_data}, 32'h1234);
        @(negedge clk);
        check("trunc_edrop", {31'h0, po_err}, 32'h0);
        check("trunc_idle", {31'h0, rx_busy}, 32'h0);
        send_frame(32'h0000_5555, 16, 1'b1, 0);
        expect_word("post_trunc", 16'h5555, 1'b0);

        // Overrun: 17-cycle valid run on a 16-bit frame; output pulses as valid drops.
        send_frame(32'h0000_C0DE, 16, 1'b1, 1);
        check("ovr_valid", {31'h0, po_valid}, 32'h1);
        check("ovr_data", {16'h0, po_data}, 32'hC0DE);
        check("ovr_err", {31'h0, po_err}, 32'h1);
        check("ovr_index", {24'h0, po_index}, {24'h0, exp_idx});
        exp_idx = exp_idx + 8'd1;
        @(negedge clk);
        check("ovr_vdrop", {31'h0, po_valid}, 32'h0);
        check("ovr_idle", {31'h0, rx_busy}, 32'h0);
        send_frame(32'h0000_1357, 16, 1'b1, 0);
        expect_word("post_ovr", 16'h1357, 1'b0);

        // Reset in the middle of a frame.
        send_frame(32'h0000_00FF, 0, 1'b1, 5);
        si_valid = 1'b1;
        check("mid_busy", {31'h0, rx_busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("mrst_data", {16'h0, po_data}, 32'h0);
        check("mrst_index", {24'h0, po_index}, 32'h0);
        check("mrst_busy", {31'h0, rx_busy}, 32'h0);
        check("mrst_verr", {30'h0, po_valid, po_err}, 32'h0);
        si_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_idx = 8'd0;
        @(negedge clk);
        send_frame(32'h0000_9A6B, 16, 1'b1, 0);
        expect_word("post_rst", 16'h9A6B, 1'b0);

        // Nonzero pad bits in a 32-bit lower-fill frame.
        set_cfg(2'b11, 1'b0, 1'b1, 1'b0);
        send_frame(32'h0001_ABCD, 32, 1'b1, 0);
        expect_word("pad", 16'hABCD, pad_err_exp);

        // 257 good 8-bit frames walk the index across the 255->0 wrap.
        set_cfg(2'b00, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 257; k++) begin
            logic [31:0] b;
            b = k;
            send_frame({24'h0, b[7:0]}, 8, 1'b1, 0);
            expect_word("wrap", {8'h00, b[7:0]}, 1'b0);
        end
        check("wrap_final", {24'h0, po_index}, {24'h0, exp_idx - 8'd1});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
